// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts busy cycles without an ack and flags the last allowed cycle.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-memory ports onto one single-ported memory with a timeout.
// Optional build macro ARB_ROUND_ROBIN_EN replaces fixed dm priority with round-robin tie-break.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_f,
    output logic              stall_m,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              pick_dm;
    logic              busy;
    logic              expired;

    assign busy = (state_q != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    // Holds the requester that was NOT granted most recently; it wins the next tie.
    gnt_e rr_next_q, rr_next_d;

    assign pick_dm = dm_req & (~if_req | (rr_next_q == GNT_DM));

    always_comb begin
        rr_next_d = rr_next_q;
        if (state_q == IDLE && (if_req || dm_req)) begin
            rr_next_d = pick_dm ? GNT_IF : GNT_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_next_q <= GNT_IF;
        end else begin
            rr_next_q <= rr_next_d;
        end
    end
`else
    assign pick_dm = dm_req;
`endif

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == IDLE),
        .enable_i  (busy & ~mem_ack),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ready  = 1'b0;
        if_rdata  = '0;
        dm_ready  = 1'b0;
        dm_rdata  = '0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                // Request fields are captured at grant so the access completes even if req drops.
                if (if_req || dm_req) begin
                    state_d = pick_dm ? BUSY_DM : BUSY_IF;
                    addr_d  = pick_dm ? dm_addr : if_addr;
                    we_d    = pick_dm & dm_we;
                    wdata_d = pick_dm ? dm_wdata : '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack || expired) begin
                    state_d = IDLE;
                    err     = ~mem_ack;
                    if (state_q == BUSY_IF) begin
                        if_ready = 1'b1;
                        if_rdata = mem_ack ? mem_rdata : '0;
                    end else begin
                        dm_ready = 1'b1;
                        dm_rdata = mem_ack ? mem_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign stall_f = if_req & ~if_ready;
    assign stall_m = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter (default fixed-priority build, TIMEOUT=4) with a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_req, mem_we, stall_f, stall_m, err;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txns   = 0;

    // Requester and memory model state
    bit          if_pend, dm_pend;
    logic [31:0] if_a, dm_a, dm_d;
    bit          dm_w;
    bit          busy, g_dm, g_we;
    logic [31:0] g_addr, g_wdata;
    int          k, ack_at;
    bit          fix_en, fix_dm_we, force_ack;
    logic [31:0] fix_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after negedge, check outputs, advance the model.
    task automatic step(input bit new_if, input bit new_dm, input int dly);
        bit ack_now, done;
        bit e_if_rdy, e_dm_rdy;
        logic [31:0] e_if_rd, e_dm_rd;
        if (!if_pend && new_if) begin
            if_pend = 1'b1;
            if_a    = fix_en ? 32'h100 : $urandom;
        end
        if (!dm_pend && new_dm) begin
            dm_pend = 1'b1;
            dm_w    = fix_en ? fix_dm_we : 1'($urandom_range(0, 1));
            dm_a    = fix_en ? 32'h40 : $urandom;
            dm_d    = fix_en ? 32'hDEADBEEF : $urandom;
        end
        if_req    = if_pend;
        if_addr   = if_a;
        dm_req    = dm_pend;
        dm_we     = dm_w;
        dm_addr   = dm_a;
        dm_wdata  = dm_d;
        ack_now   = busy && (k == ack_at);
        mem_ack   = ack_now | force_ack | (!busy && $urandom_range(0, 7) == 0);
        mem_rdata = fix_en ? fix_rdata : $urandom;
        #1;
        done     = busy && (ack_now || k == TO);
        e_if_rdy = done && !g_dm;
        e_dm_rdy = done && g_dm;
        e_if_rd  = (e_if_rdy && ack_now) ? mem_rdata : 32'h0;
        e_dm_rd  = (e_dm_rdy && ack_now) ? mem_rdata : 32'h0;
        check("mem_req",   64'(mem_req),   64'(busy));
        check("mem_we",    64'(mem_we),    64'(busy && g_we));
        check("mem_addr",  64'(mem_addr),  busy ? 64'(g_addr) : 64'h0);
        check("mem_wdata", 64'(mem_wdata), busy ? 64'(g_wdata) : 64'h0);
        check("if_ready",  64'(if_ready),  64'(e_if_rdy));
        check("if_rdata",  64'(if_rdata),  64'(e_if_rd));
        check("dm_ready",  64'(dm_ready),  64'(e_dm_rdy));
        check("dm_rdata",  64'(dm_rdata),  64'(e_dm_rd));
        check("err",       64'(err),       64'(done && !ack_now));
        check("stall_f",   64'(stall_f),   64'(if_pend && !e_if_rdy));
        check("stall_m",   64'(stall_m),   64'(dm_pend && !e_dm_rdy));
        if (busy) begin
            if (done) begin
                txns++;
                $display("txn %0d port=%s addr=%h we=%0d wdata=%h rdata=%h err=%0d",
                         txns, g_dm ? "dm" : "if", g_addr, g_we, g_wdata,
                         g_dm ? e_dm_rd : e_if_rd, !ack_now);
                busy = 1'b0;
                if (g_dm) dm_pend = 1'b0;
                else      if_pend = 1'b0;
            end else begin
                k++;
            end
        end else if (dm_pend || if_pend) begin
            busy    = 1'b1;
            g_dm    = dm_pend;
            g_addr  = dm_pend ? dm_a : if_a;
            g_we    = dm_pend && dm_w;
            g_wdata = dm_pend ? dm_d : 32'h0;
            k       = 1;
            ack_at  = dly;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        if_pend = 1'b0;
        dm_pend = 1'b0;
        busy    = 1'b0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        fix_en = 1'b0; fix_dm_we = 1'b0; force_ack = 1'b0; fix_rdata = 32'h0;
        if_a = 0; dm_a = 0; dm_d = 0; dm_w = 0;
        g_dm = 0; g_we = 0; g_addr = 0; g_wdata = 0; k = 0; ack_at = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_we = 0; mem_rdata = 0;
        @(negedge clk);
        do_reset();
        step(1'b0, 1'b0, 1);

        // Single fetch, ack in first busy cycle
        fix_en = 1'b1; fix_rdata = 32'h00A00513;
        step(1'b1, 1'b0, 1);
        step(1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 1);

        // Simultaneous fetch and store: dm first, then fetch
        fix_dm_we = 1'b1;
        step(1'b1, 1'b1, 1);
        step(1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 1);

        // dm read with no ack: timeout; then ack coinciding with the last allowed cycle
        fix_dm_we = 1'b0; fix_rdata = 32'h55;
        step(1'b0, 1'b1, TO + 2);
        repeat (TO + 1) step(1'b0, 1'b0, 1);
        step(1'b0, 1'b1, TO);
        repeat (TO + 1) step(1'b0, 1'b0, 1);
        fix_en = 1'b0;

        // Reset during the second BUSY_IF cycle, then a late ack
        step(1'b1, 1'b0, 6);
        step(1'b0, 1'b0, 1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1);
        rst = 1'b0; busy = 1'b0; if_pend = 1'b0; force_ack = 1'b1;
        step(1'b0, 1'b0, 1);
        force_ack = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(1, TO + 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
